// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer and its register files.
package core_seq_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned INSTR_W   = 32;

  // One register index; read-port index arrays are reg_idx_t [RD_PORTS-1:0].
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } seq_state_e;

endpackage

// File: rtl/core_sequencer_if.sv
// Fetch, decode and execute handshake bundle between the sequencer and its neighbours.
interface core_sequencer_if
  import core_seq_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RD_PORTS = 3
);

  logic                          fetch_req;
  logic                          fetch_ack;
  logic [XLEN-1:0]               pc;
  logic [INSTR_W-1:0]            instruction;

  logic [INSTR_W-1:0]            dec_instruction;
  logic [RD_PORTS*REG_IDX_W-1:0] dec_rd_num;
  logic [REG_IDX_W-1:0]          dec_wr_num;
  logic                          dec_wr_general;
  logic                          dec_wr_float;

  logic                          exec_req;
  logic                          exec_ack;
  logic [RD_PORTS*XLEN-1:0]      general_in_regs;
  logic [RD_PORTS*XLEN-1:0]      float_in_regs;
  logic [XLEN-1:0]               exec_reg_out;
  logic [XLEN-1:0]               exec_pc_out;
  logic                          exec_halt;

  modport master (
    output fetch_req, pc, dec_instruction, exec_req, general_in_regs, float_in_regs,
    input  fetch_ack, instruction, dec_rd_num, dec_wr_num, dec_wr_general, dec_wr_float,
    input  exec_ack, exec_reg_out, exec_pc_out, exec_halt
  );

  modport slave (
    input  fetch_req, pc, dec_instruction, exec_req, general_in_regs, float_in_regs,
    output fetch_ack, instruction, dec_rd_num, dec_wr_num, dec_wr_general, dec_wr_float,
    output exec_ack, exec_reg_out, exec_pc_out, exec_halt
  );

endinterface

// File: rtl/core_regfile.sv
// Register file: one write port, RD_PORTS asynchronous read ports.
// Out-of-range indices are write-ignored and read as zero; ZERO_REG pins entry 0 to zero.
module core_regfile
  import core_seq_pkg::*;
#(
  parameter int unsigned COUNT    = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RD_PORTS = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  reg_idx_t                 waddr,
  input  logic [XLEN-1:0]          wdata,
  input  reg_idx_t [RD_PORTS-1:0]  raddr,
  output logic [RD_PORTS*XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [COUNT];
  logic [XLEN-1:0] mem_d [COUNT];

  // Next contents: apply the single write when the index names a real, writable entry.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (we && (waddr == REG_IDX_W'(i)) && !(ZERO_REG && (i == 0))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports: zero unless the index hits a stored, readable entry.
  always_comb begin
    rdata = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      for (int unsigned i = 0; i < COUNT; i++) begin
        if ((raddr[p] == REG_IDX_W'(i)) && !(ZERO_REG && (i == 0))) begin
          rdata[p*XLEN +: XLEN] = mem_q[i];
        end
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Fetch/decode/execute/writeback sequencer owning the PC and the general and float register files.
// Optional macro CORE_SEQUENCER_RETIRE_COUNT_EN adds a 64-bit retired-instruction counter output.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     GREG_COUNT = 32,
  parameter int unsigned     FREG_COUNT = 32,
  parameter int unsigned     RD_PORTS   = 3,
  parameter logic [XLEN-1:0] PC_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             halted,
  core_sequencer_if.master bus
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
  ,
  output logic [63:0]      retired
`endif
);

  localparam logic [XLEN-1:0] PC_MASK    = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_RST_VAL = PC_RESET & PC_MASK;

  seq_state_e               state_q, state_d;
  logic                     fetch_req_q, fetch_req_d;
  logic                     exec_req_q, exec_req_d;
  logic                     halted_q, halted_d;
  logic                     sticky_halt_q, sticky_halt_d;
  logic [XLEN-1:0]          pc_q, pc_d;
  logic [INSTR_W-1:0]       instr_q, instr_d;
  reg_idx_t [RD_PORTS-1:0]  rd_idx_q, rd_idx_d;
  reg_idx_t                 wr_idx_q, wr_idx_d;
  logic                     wr_gen_q, wr_gen_d;
  logic                     wr_flt_q, wr_flt_d;
  logic [XLEN-1:0]          res_q, res_d;
  logic [XLEN-1:0]          npc_q, npc_d;
  logic                     xhalt_q, xhalt_d;

  logic                     fetch_fire;
  logic                     exec_fire;
  logic                     wb_cycle;

  assign fetch_fire = fetch_req_q && bus.fetch_ack;
  assign exec_fire  = exec_req_q && bus.exec_ack;
  assign wb_cycle   = (state_q == S_WB);

  // Next state, latched transaction data and registered handshake outputs.
  always_comb begin
    state_d       = state_q;
    sticky_halt_d = sticky_halt_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    rd_idx_d      = rd_idx_q;
    wr_idx_d      = wr_idx_q;
    wr_gen_d      = wr_gen_q;
    wr_flt_d      = wr_flt_q;
    res_d         = res_q;
    npc_d         = npc_q;
    xhalt_d       = xhalt_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = run ? S_FETCH : S_HALT;
      end
      S_FETCH: begin
        if (fetch_fire) begin
          instr_d = bus.instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rd_idx_d = bus.dec_rd_num;
        wr_idx_d = bus.dec_wr_num;
        wr_gen_d = bus.dec_wr_general;
        wr_flt_d = bus.dec_wr_float;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (exec_fire) begin
          res_d   = bus.exec_reg_out;
          npc_d   = bus.exec_pc_out;
          xhalt_d = bus.exec_halt;
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d = npc_q & PC_MASK;
        if (xhalt_q) begin
          sticky_halt_d = 1'b1;
          state_d       = S_HALT;
        end else if (!run) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        // An executor-requested halt is left only through reset.
        if (!sticky_halt_q && run) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    fetch_req_d = (state_d == S_FETCH);
    exec_req_d  = (state_d == S_EXEC);
    halted_d    = (state_d == S_HALT);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_req_q   <= 1'b0;
      exec_req_q    <= 1'b0;
      halted_q      <= 1'b0;
      sticky_halt_q <= 1'b0;
      pc_q          <= PC_RST_VAL;
      instr_q       <= '0;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      wr_gen_q      <= 1'b0;
      wr_flt_q      <= 1'b0;
      res_q         <= '0;
      npc_q         <= '0;
      xhalt_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_req_q   <= fetch_req_d;
      exec_req_q    <= exec_req_d;
      halted_q      <= halted_d;
      sticky_halt_q <= sticky_halt_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      rd_idx_q      <= rd_idx_d;
      wr_idx_q      <= wr_idx_d;
      wr_gen_q      <= wr_gen_d;
      wr_flt_q      <= wr_flt_d;
      res_q         <= res_d;
      npc_q         <= npc_d;
      xhalt_q       <= xhalt_d;
    end
  end

  // General registers; entry 0 is hardwired to zero.
  core_regfile #(
    .COUNT    (GREG_COUNT),
    .XLEN     (XLEN),
    .RD_PORTS (RD_PORTS),
    .ZERO_REG (1'b1)
  ) u_greg (
    .clk   (clk),
    .rst_n (reset),
    .we    (wb_cycle && wr_gen_q),
    .waddr (wr_idx_q),
    .wdata (res_q),
    .raddr (rd_idx_q),
    .rdata (bus.general_in_regs)
  );

  // Float registers; entry 0 is an ordinary register.
  core_regfile #(
    .COUNT    (FREG_COUNT),
    .XLEN     (XLEN),
    .RD_PORTS (RD_PORTS),
    .ZERO_REG (1'b0)
  ) u_freg (
    .clk   (clk),
    .rst_n (reset),
    .we    (wb_cycle && wr_flt_q),
    .waddr (wr_idx_q),
    .wdata (res_q),
    .raddr (rd_idx_q),
    .rdata (bus.float_in_regs)
  );

  assign halted              = halted_q;
  assign bus.fetch_req       = fetch_req_q;
  assign bus.exec_req        = exec_req_q;
  assign bus.pc              = pc_q;
  assign bus.dec_instruction = instr_q;

`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
  logic [63:0] retired_q, retired_d;

  // Count one retirement per writeback cycle, wrapping naturally.
  always_comb begin
    retired_d = retired_q;
    if (wb_cycle) begin
      retired_d = retired_q + 64'(1);
    end
  end

  // Retirement counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: randomized instruction stream against a register/PC model.
`timescale 1ns/1ps
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned GREG = 32;
  localparam int unsigned FREG = 16;
  localparam int unsigned RDP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic halted;
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
  logic [63:0] retired;
`endif

  core_sequencer_if #(.XLEN(XLEN), .RD_PORTS(RDP)) bus_if ();

  core_sequencer #(
    .XLEN       (XLEN),
    .GREG_COUNT (GREG),
    .FREG_COUNT (FREG),
    .RD_PORTS   (RDP),
    .PC_RESET   (32'h0000_0103)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .run    (run),
    .halted (halted),
    .bus    (bus_if)
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
    ,
    .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Architectural model
  logic [XLEN-1:0] m_greg [GREG];
  logic [XLEN-1:0] m_freg [FREG];
  logic [XLEN-1:0] m_pc;
  longint unsigned m_retired;

  function automatic logic [XLEN-1:0] m_gread(input logic [4:0] ix);
    if (ix == 5'd0) return '0;
    return m_greg[ix];
  endfunction

  function automatic logic [XLEN-1:0] m_fread(input logic [4:0] ix);
    if (int'(ix) >= FREG) return '0;
    return m_freg[ix[3:0]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < GREG; i++) m_greg[i] = '0;
    for (int i = 0; i < FREG; i++) m_freg[i] = '0;
    m_pc      = 32'h0000_0100;
    m_retired = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.fetch_ack      = 1'b0;
    bus_if.instruction    = '0;
    bus_if.dec_rd_num     = '0;
    bus_if.dec_wr_num     = '0;
    bus_if.dec_wr_general = 1'b0;
    bus_if.dec_wr_float   = 1'b0;
    bus_if.exec_ack       = 1'b0;
    bus_if.exec_reg_out   = '0;
    bus_if.exec_pc_out    = '0;
    bus_if.exec_halt      = 1'b0;
  endtask

  // One full instruction, starting with the DUT in FETCH. Checks protocol, operands and PC.
  task automatic do_instr(input logic [31:0] ins, input logic [14:0] rd, input logic [4:0] wr,
                          input logic gen, input logic flt, input logic [31:0] res,
                          input logic [31:0] npc, input logic xh, input int fw, input int ew,
                          input bit drop_run, input bit spur);
    logic exp_halt;
    logic [4:0] ix;
    checks++;
    if (bus_if.fetch_req !== 1'b1 || bus_if.pc !== m_pc) begin
      errors++;
      $display("FAIL instr_start: fetch_req=%b pc=%h, expected fetch_req=1 pc=%h",
               bus_if.fetch_req, bus_if.pc, m_pc);
    end
    bus_if.dec_rd_num     = rd;
    bus_if.dec_wr_num     = wr;
    bus_if.dec_wr_general = gen;
    bus_if.dec_wr_float   = flt;
    bus_if.exec_reg_out   = res;
    bus_if.exec_pc_out    = npc;
    bus_if.exec_halt      = xh;
    for (int i = 0; i < fw; i++) begin
      tick();
      if (drop_run && i == 0) run = 1'b0;
    end
    checks++;
    if (bus_if.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_held: fetch_req=%b after %0d wait cycles, expected 1", bus_if.fetch_req, fw);
    end
    bus_if.instruction = ins;
    bus_if.fetch_ack   = 1'b1;
    tick();
    // DECODE: present acks with no request outstanding; they must be ignored.
    bus_if.fetch_ack    = spur;
    bus_if.instruction  = ~ins;
    bus_if.exec_ack     = spur;
    bus_if.exec_reg_out = ~res;
    checks++;
    if (bus_if.dec_instruction !== ins || bus_if.fetch_req !== 1'b0 || bus_if.exec_req !== 1'b0) begin
      errors++;
      $display("FAIL decode: dec_instruction=%h fetch_req=%b exec_req=%b, expected %h 0 0",
               bus_if.dec_instruction, bus_if.fetch_req, bus_if.exec_req, ins);
    end
    tick();
    bus_if.fetch_ack    = 1'b0;
    bus_if.exec_ack     = 1'b0;
    bus_if.exec_reg_out = res;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) repeat (ew) tick();
      checks++;
      if (bus_if.exec_req !== 1'b1 || bus_if.dec_instruction !== ins) begin
        errors++;
        $display("FAIL exec_phase%0d: exec_req=%b dec_instruction=%h, expected 1 %h",
                 pass, bus_if.exec_req, bus_if.dec_instruction, ins);
      end
      for (int p = 0; p < RDP; p++) begin
        ix = rd[p*5 +: 5];
        checks++;
        if (bus_if.general_in_regs[p*XLEN +: XLEN] !== m_gread(ix)) begin
          errors++;
          $display("FAIL gen_operand p%0d idx%0d: got %h expected %h",
                   p, ix, bus_if.general_in_regs[p*XLEN +: XLEN], m_gread(ix));
        end
        checks++;
        if (bus_if.float_in_regs[p*XLEN +: XLEN] !== m_fread(ix)) begin
          errors++;
          $display("FAIL flt_operand p%0d idx%0d: got %h expected %h",
                   p, ix, bus_if.float_in_regs[p*XLEN +: XLEN], m_fread(ix));
        end
      end
    end
    bus_if.exec_ack = 1'b1;
    tick();
    // WB: scramble executor outputs; only the latched values may be used.
    bus_if.exec_ack     = 1'b0;
    bus_if.exec_reg_out = ~res;
    bus_if.exec_pc_out  = ~npc;
    bus_if.exec_halt    = ~xh;
    checks++;
    if (bus_if.exec_req !== 1'b0 || bus_if.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL wb: exec_req=%b fetch_req=%b, expected 0 0", bus_if.exec_req, bus_if.fetch_req);
    end
    tick();
    bus_if.exec_halt = 1'b0;
    if (gen && wr != 5'd0) m_greg[wr] = res;
    if (flt && int'(wr) < FREG) m_freg[wr[3:0]] = res;
    m_pc = {npc[31:2], 2'b00};
    m_retired++;
    exp_halt = xh || !run;
    checks++;
    if (halted !== exp_halt || bus_if.fetch_req !== !exp_halt || bus_if.pc !== m_pc) begin
      errors++;
      $display("FAIL after_wb: halted=%b fetch_req=%b pc=%h, expected %b %b %h",
               halted, bus_if.fetch_req, bus_if.pc, exp_halt, !exp_halt, m_pc);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    run   = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    checks++;
    if (bus_if.fetch_req !== 1'b0 || bus_if.exec_req !== 1'b0 || halted !== 1'b0 ||
        bus_if.pc !== 32'h100 || bus_if.dec_instruction !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: fetch_req=%b exec_req=%b halted=%b pc=%h dec=%h, expected 0 0 0 00000100 00000000",
               bus_if.fetch_req, bus_if.exec_req, halted, bus_if.pc, bus_if.dec_instruction);
    end
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
    checks++;
    if (retired !== 64'd0) begin
      errors++;
      $display("FAIL reset_retired: got %0d expected 0", retired);
    end
`endif
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_if.fetch_req !== 1'b1 || bus_if.pc !== 32'h100 || halted !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: fetch_req=%b pc=%h halted=%b, expected 1 00000100 0",
               bus_if.fetch_req, bus_if.pc, halted);
    end
  endtask

  task automatic test_write_read();
    do_instr(32'h0000_0011, 15'd0, 5'd5, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h104, 1'b0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (bus_if.pc !== 32'h104) begin
      errors++;
      $display("FAIL pc_after_first: got %h expected 00000104", bus_if.pc);
    end
    do_instr(32'h0000_0022, {5'd0, 5'd0, 5'd5}, 5'd0, 1'b0, 1'b0, 32'h0, 32'h108, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_reg();
    do_instr(32'h0000_0033, 15'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 32'h10C, 1'b0, 1, 1, 1'b0, 1'b1);
    do_instr(32'h0000_0044, {5'd0, 5'd0, 5'd0}, 5'd20, 1'b0, 1'b1, 32'h5555, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr(32'h0000_0055, {5'd20, 5'd0, 5'd5}, 5'd3, 1'b1, 1'b0, 32'h77, 32'h200, 1'b0, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, 15'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), $urandom,
               $urandom, 1'b0, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'b0, 1'($urandom));
    end
  endtask

  task automatic test_run_low_fetch();
    logic [31:0] ins;
    ins = 32'hA5A5_0001;
    do_instr(ins, {5'd1, 5'd2, 5'd3}, 5'd9, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0400, 1'b0, 5, 0, 1'b1, 1'b0);
    bus_if.fetch_ack = 1'b1;
    repeat (3) tick();
    bus_if.fetch_ack = 1'b0;
    checks++;
    if (halted !== 1'b1 || bus_if.fetch_req !== 1'b0 || bus_if.dec_instruction !== ins) begin
      errors++;
      $display("FAIL halt_hold: halted=%b fetch_req=%b dec=%h, expected 1 0 %h",
               halted, bus_if.fetch_req, bus_if.dec_instruction, ins);
    end
    run = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b0 || bus_if.fetch_req !== 1'b1 || bus_if.pc !== 32'h400) begin
      errors++;
      $display("FAIL resume: halted=%b fetch_req=%b pc=%h, expected 0 1 00000400",
               halted, bus_if.fetch_req, bus_if.pc);
    end
    do_instr(32'h0000_0066, {5'd9, 5'd9, 5'd9}, 5'd0, 1'b0, 1'b0, 32'h0, 32'h404, 1'b0, 0, 0, 1'b0, 1'b0);
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
    checks++;
    if (retired !== 64'(m_retired)) begin
      errors++;
      $display("FAIL retired_count: got %0d expected %0d", retired, m_retired);
    end
`endif
  endtask

  task automatic test_exec_halt();
    do_instr(32'h0000_0077, 15'd0, 5'd4, 1'b1, 1'b0, 32'h4444, 32'h0000_0500, 1'b1, 0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run = 1'(k);
      repeat (3) tick();
      checks++;
      if (halted !== 1'b1 || bus_if.fetch_req !== 1'b0) begin
        errors++;
        $display("FAIL exec_halt_sticky run=%0d: halted=%b fetch_req=%b, expected 1 0",
                 k, halted, bus_if.fetch_req);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    rst_n = 1'b0;
    clear_inputs();
    run = 1'b1;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (halted !== 1'b0 || bus_if.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_halt: halted=%b fetch_req=%b, expected 0 1", halted, bus_if.fetch_req);
    end
    bus_if.dec_wr_num     = 5'd7;
    bus_if.dec_wr_general = 1'b1;
    bus_if.exec_reg_out   = 32'h9999_0000;
    bus_if.exec_pc_out    = 32'h0000_0800;
    bus_if.fetch_ack      = 1'b1;
    tick();
    bus_if.fetch_ack = 1'b0;
    tick();
    checks++;
    if (bus_if.exec_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec: exec_req=%b expected 1", bus_if.exec_req);
    end
    bus_if.exec_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.exec_req !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: exec_req=%b expected 0", bus_if.exec_req);
    end
    tick();
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_if.pc !== 32'h100 || bus_if.fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: pc=%h fetch_req=%b, expected 00000100 1", bus_if.pc, bus_if.fetch_req);
    end
`ifdef CORE_SEQUENCER_RETIRE_COUNT_EN
    checks++;
    if (retired !== 64'd0) begin
      errors++;
      $display("FAIL post_reset_retired: got %0d expected 0", retired);
    end
`endif
    do_instr(32'h0000_0088, {5'd4, 5'd7, 5'd5}, 5'd0, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_random();
    test_run_low_fetch();
    test_exec_halt();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Parametrised successor to the core's fetch/decode/execute controller. Sequences fetch, decode, execute and writeback through request/acknowledge handshakes instead of held-in-reset sub-units, and owns the general and float register files and the PC. Adds a run/halt control, an executor-signalled halt, and configurable register and read-port counts. Sits between the fetcher, the external decoder and the executor.

Parameters:
XLEN, 32, datapath, PC and register width
GREG_COUNT, 32, number of general registers; register 0 reads as zero
FREG_COUNT, 32, number of float registers
RD_PORTS, 3, number of source-register read ports
PC_RESET, 0, PC value after reset; bits [1:0] are ignored

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
run  in  1  level; when 0, the sequencer stops at the next instruction boundary
halted  out  1  1 while in HALT
fetch_req  out  1  fetch request, held until ack
fetch_ack  in  1  fetch done; instruction valid this cycle
pc  out  XLEN  current instruction address; bits [1:0] always 0
instruction  in  32  fetched word, sampled on fetch_req&&fetch_ack
dec_instruction  out  32  latched instruction, to the decoder
dec_rd_num  in  RD_PORTS*5  decoder source-register indices
dec_wr_num  in  5  decoder destination index
dec_wr_general  in  1  destination is a general register
dec_wr_float  in  1  destination is a float register
exec_req  out  1  execute request, held until ack
exec_ack  in  1  execution done; result, next PC and halt valid this cycle
general_in_regs  out  RD_PORTS*XLEN  general operands, stable throughout EXEC
float_in_regs  out  RD_PORTS*XLEN  float operands, stable throughout EXEC
exec_reg_out  in  XLEN  result
exec_pc_out  in  XLEN  next PC
exec_halt  in  1  the instruction requests a halt

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; pc=PC_RESET&~3; all registers 0; fetch_req=0; exec_req=0; halted=0; dec_instruction=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. The state enum is defined in the package.
- IDLE->FETCH when run=1; IDLE->HALT when run=0.
- FETCH: fetch_req=1. On fetch_ack, latch instruction into dec_instruction and go to DECODE. A fetch is never abandoned, even if run falls.
- DECODE: one cycle. Latch dec_rd_num, dec_wr_num and the write flags into internal registers, then go to EXEC. Operands are read combinationally from the latched indices.
- EXEC: exec_req=1. On exec_ack, latch exec_reg_out, exec_pc_out and exec_halt, then go to WB.
- WB: one cycle.
  - Write the result to the general register if its write flag is set and index!=0; write it to the float register if its write flag is set and index<FREG_COUNT.
  - If both flags are set, both files are written.
  - pc <= latched next PC with bits [1:0]=0. The PC wraps modulo 2^XLEN with no error.
  - Next state is HALT if latched halt=1 or run=0; otherwise FETCH.
- HALT: halted=1. Register files are frozen. HALT->FETCH on run=1 only if the halt was caused by run=0. A halt caused by exec_halt is exited only by reset.
- Index range: writes to indices >=GREG_COUNT or >=FREG_COUNT are ignored; reads from them return 0.
- Register 0: reads 0 at all times; a write to it is dropped.
- Latency: minimum 4 cycles per instruction (FETCH and EXEC each 1 cycle with an immediate ack, plus DECODE and WB). Each extra ack wait adds one cycle.
- An ack arriving while its req=0 is ignored.
- Reset mid-transaction drops the request immediately. Any in-flight result is discarded.

Optional Feature:
- Macro: CORE_SEQUENCER_RETIRE_COUNT_EN.
- When defined: adds output retired (64 bits), which increments once per WB cycle, is reset to 0 by reset, and wraps at 2^64.
- When undefined: the port and the counter are absent.

Decomposition:
- Package core_seq_pkg holds:
  - the state enum;
  - constant REG_IDX_W=5;
  - the read-port index array type.
- Sub-module core_regfile is parametrised by COUNT, XLEN, RD_PORTS and ZERO_REG. It has one write port and RD_PORTS asynchronous read ports, and is instantiated twice: general with ZERO_REG=1, float with ZERO_REG=0.

Test Plan:
- Reset with PC_RESET=0x103, run=1 -> pc=0x100 and fetch_req=1 in the first cycle after release.
- Immediate acks; execute "r5<-0xDEADBEEF" (general flag, index 5), exec_pc_out=0x104 -> r5 reads 0xDEADBEEF on general_in_regs on the next fetch; pc=0x104; 4 cycles per instruction.
- Write with index 0 and the general flag, value 0x1234 -> r0 still reads 0; a float write to index 0 stores 0x1234.
- exec_halt=1 on the ack -> halted=1 after WB; run toggled 0->1 leaves it halted; only reset clears it.
- run=0 during a 5-cycle fetch wait -> the instruction completes, then HALT; run=1 -> FETCH resumes at exec_pc_out.
- reset asserted mid-EXEC with exec_req=1 -> exec_req=0 the same cycle (asynchronous); no register or PC update; retired=0 when CORE_SEQUENCER_RETIRE_COUNT_EN is defined.
